serial_deframer: RTL and testbench

- Serial-to-parallel receive stage that sits directly downstream of the 8-bit bidirectional shift register.
- Consumes its serial output (SOL when shifting left, SOR when shifting right) one bit per bit_en strobe.
- Strips start/stop framing, reassembles the data word in the bit order matching the shift direction, and presents it on a valid/ready parallel interface.
- Flags framing errors and overruns.

---
 rtl/serial_pkg.sv | 27 ++
 rtl/serial_out_reg.sv | 47 ++++
 rtl/serial_deframer.sv | 151 +++++++++++++++
 tb/tb_serial_deframer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial deframer
// Contents:
//   state_t    FSM states IDLE, DATA, PARITY, STOP
//   START_BIT  line level of a start bit
//   STOP_BIT   line level of a stop bit
//   DIR_LEFT   lr value for a left shift (MSB first)
//   DIR_RIGHT  lr value for a right shift (LSB first)
//   cnt_width  width of a counter that can hold 0..data_w
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_out_reg.sv
// rtl/serial_out_reg.sv - single-entry valid/ready holding register with overrun detect
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        a completed word is offered this cycle
//   din         word offered with load
//   dout        held word, stable while dout_valid is 1
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts; transfer when dout_valid && dout_ready
//   overrun     one-cycle pulse: offered word dropped because the entry stayed full
module serial_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              overrun
);

  logic xfer;
  logic accept;

  assign xfer   = dout_valid && dout_ready;
  // A word may enter when the entry is empty, or when the current word is
  // leaving in this same cycle.
  assign accept = load && (!dout_valid || dout_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= load && !accept;
      if (accept) begin
        dout       <= din;
        dout_valid <= 1'b1;
      end else if (xfer) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_deframer.sv
// rtl/serial_deframer.sv - serial-to-parallel receiver with start/stop framing
// Optional feature macro: SERIAL_DEFRAMER_PARITY_EN (even parity bit after the data bits)
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   sdi         serial data from the shift register (SOL/SOR)
//   bit_en      bit strobe; sdi sampled only when 1
//   lr          0 = MSB first (left shift), 1 = LSB first (right shift); latched at start bit
//   dout        received word
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts
//   busy        frame reception in progress
//   frame_err   one-cycle pulse: stop bit sampled as 0
//   overrun     one-cycle pulse: completed word dropped, output still full
//   parity_err  one-cycle pulse: parity mismatch (0 when parity is not built)
module serial_deframer
  import serial_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdi,
  input  logic              bit_en,
  input  logic              lr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CW = cnt_width(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              lr_q, lr_n;
  logic              word_done;
  logic              ferr_n;
  logic              perr_n;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic              par_q, par_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      lr_q      <= DIR_LEFT;
      frame_err <= 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
      par_q      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      lr_q      <= lr_n;
      frame_err <= ferr_n;
`ifdef SERIAL_DEFRAMER_PARITY_EN
      par_q      <= par_n;
      parity_err <= perr_n;
`endif
    end
  end

`ifndef SERIAL_DEFRAMER_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = cnt;
    lr_n      = lr_q;
    word_done = 1'b0;
    ferr_n    = 1'b0;
    perr_n    = 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
    par_n     = par_q;
`endif
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (sdi == START_BIT) begin
            lr_n    = lr;
            cnt_n   = '0;
            state_n = DATA;
          end
        end
        DATA: begin
          // After DATA_W shifts the first bit received sits at the MSB for
          // a left shift and at the LSB for a right shift.
          if (lr_q == DIR_LEFT) shreg_n = {shreg[DATA_W-2:0], sdi};
          else                  shreg_n = {sdi, shreg[DATA_W-1:1]};
          cnt_n = cnt + 1'b1;
          if (cnt == LAST_BIT) begin
`ifdef SERIAL_DEFRAMER_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
`ifdef SERIAL_DEFRAMER_PARITY_EN
        PARITY: begin
          par_n   = sdi;
          state_n = STOP;
        end
`endif
        STOP: begin
          state_n = IDLE;
          // Framing error wins over parity error; only a clean frame is
          // offered to the output register, so the pulses never coincide.
          if (sdi != STOP_BIT) begin
            ferr_n = 1'b1;
`ifdef SERIAL_DEFRAMER_PARITY_EN
          end else if ((^shreg) ^ par_q) begin
            perr_n = 1'b1;
`endif
          end else begin
            word_done = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  serial_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (word_done),
    .din        (shreg),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_deframer.sv
// tb/tb_serial_deframer.sv - self-checking bench for serial_deframer
module tb_serial_deframer;

  localparam int DW = 8;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FN = DW + 2 + P;  // start + data + parity + stop

  logic          clk = 1'b0;
  logic          rst;
  logic          sdi;
  logic          bit_en;
  logic          lr;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  serial_deframer #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sdi        (sdi),
    .bit_en     (bit_en),
    .lr         (lr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collects the bits of a frame and decides its fate once
  // the whole frame has been seen.
  logic [DW-1:0] m_dout = '0;
  bit m_valid = 0, m_busy = 0, m_ferr = 0, m_ovr = 0, m_perr = 0;
  bit in_frame = 0, mlr = 0;
  bit bits[$];

  always @(posedge clk) begin
    bit xfer, loaded;
    int par, idx;
    logic [DW-1:0] w;
    if (rst) begin
      m_dout = '0; m_valid = 0; m_busy = 0; m_ferr = 0; m_ovr = 0; m_perr = 0;
      in_frame = 0; bits.delete();
    end else begin
      m_ferr = 0; m_ovr = 0; m_perr = 0;
      xfer = m_valid && dout_ready;
      loaded = 0;
      if (bit_en) begin
        if (!in_frame) begin
          if (sdi == 1'b0) begin
            in_frame = 1; mlr = lr; bits.delete();
          end
        end else begin
          bits.push_back(sdi);
          if (bits.size() == FN - 1) begin
            in_frame = 0;
            par = 0;
            for (int i = 0; i < DW + P; i++) par ^= int'(bits[i]);
            if (!bits[FN-2]) m_ferr = 1;
            else if (P == 1 && par != 0) m_perr = 1;
            else begin
              w = '0;
              for (int i = 0; i < DW; i++) begin
                idx = mlr ? i : DW - 1 - i;
                w[idx] = bits[i];
              end
              if (!m_valid || dout_ready) begin
                m_dout = w; m_valid = 1; loaded = 1;
              end else m_ovr = 1;
            end
          end
        end
      end
      if (xfer && !loaded) m_valid = 0;
      m_busy = in_frame;
    end
  end

  // Per-cycle compare plus bookkeeping of what the DUT delivered.
  logic [DW-1:0] got[$];
  int ferr_seen = 0, ovr_seen = 0, perr_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_perr", parity_err, 0);
    end else begin
      chk("dout", dout, m_dout);
      chk("dout_valid", dout_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
      chk("parity_err", parity_err, m_perr);
      if (dout_valid && dout_ready) got.push_back(dout);
      ferr_seen += int'(frame_err);
      ovr_seen  += int'(overrun);
      perr_seen += int'(parity_err);
    end
  end

  function automatic logic [31:0] mk_frame(input logic [DW-1:0] d, input bit msb_first,
                                           input bit stop, input bit par);
    logic [31:0] s;
    s = '0;
    s[0] = 1'b0;
    for (int i = 0; i < DW; i++) s[1+i] = msb_first ? d[DW-1-i] : d[i];
    if (P == 1) s[DW+1] = par;
    s[FN-1] = stop;
    return s;
  endfunction

  function automatic logic [31:0] good(input logic [DW-1:0] d, input bit msb_first);
    return mk_frame(d, msb_first, 1'b1, ^d);
  endfunction

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [31:0] seq, input int n, input bit dir, input int gap,
                      input bit toggle, input bit rdy_stop);
    logic rdy_save;
    rdy_save = dout_ready;
    for (int k = 0; k < n; k++) begin
      sdi = seq[k];
      bit_en = 1'b1;
      if (k == 0) lr = dir;
      else if (k == 1 && toggle) lr = ~dir;
      if (rdy_stop && k == n - 1) dout_ready = 1'b1;
      step();
      bit_en = 1'b0;
      if (rdy_stop && k == n - 1) dout_ready = rdy_save;
      for (int g = 0; g < gap; g++) begin
        sdi = 1'($urandom_range(0, 1));
        step();
      end
    end
    sdi = 1'b1;
  endtask

  int f0, o0, n0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sdi = 1'b1; bit_en = 1'b0; lr = 1'b0; dout_ready = 1'b1;
    idle(2);
    chk("lit_rst_valid", dout_valid, 0);
    chk("lit_rst_busy", busy, 0);
    rst = 1'b0;
    idle(2);

    // lr=0, MSB first: 0,1,0,1,1,0,0,1,0,1 -> 0xB2
    n0 = got.size(); f0 = ferr_seen; o0 = ovr_seen;
    send(good(8'hB2, 1), FN, 1'b0, 0, 1'b0, 1'b0);
    idle(3);
    chk("t1_count", got.size(), n0 + 1);
    if (got.size() > 0) chk("t1_word", got[$], 8'hB2);
    chk("t1_errs", ferr_seen + ovr_seen, f0 + o0);

    // Same bits with lr=1 -> 0x4D
    send(good(8'hB2, 1), FN, 1'b1, 0, 1'b0, 1'b0);
    idle(3);
    if (got.size() > 0) chk("t2_word", got[$], 8'h4D);

    // lr=1 latched, toggled after start bit: still LSB first
    send(good(8'h96, 0), FN, 1'b1, 0, 1'b1, 1'b0);
    idle(3);
    if (got.size() > 0) chk("t2_toggle", got[$], 8'h96);

    // Bad stop bit after 0xFF, then 0x3C
    n0 = got.size(); f0 = ferr_seen;
    send(mk_frame(8'hFF, 1, 1'b0, 1'b0), FN, 1'b0, 0, 1'b0, 1'b0);
    idle(3);
    chk("t3_ferr", ferr_seen, f0 + 1);
    chk("t3_nodata", got.size(), n0);
    send(good(8'h3C, 1), FN, 1'b0, 0, 1'b0, 1'b0);
    idle(3);
    if (got.size() > 0) chk("t3_word", got[$], 8'h3C);

    // Gapped strobe, 1 of 4 cycles
    send(good(8'h5A, 0), FN, 1'b1, 3, 1'b0, 1'b0);
    idle(3);
    if (got.size() > 0) chk("gap_word", got[$], 8'h5A);

    // Overrun: consumer stalled, back-to-back 0x11 then 0x22
    dout_ready = 1'b0;
    o0 = ovr_seen;
    send(good(8'h11, 1), FN, 1'b0, 0, 1'b0, 1'b0);
    send(good(8'h22, 1), FN, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    chk("t4_held", dout, 8'h11);
    chk("t4_ovr", ovr_seen, o0 + 1);
    dout_ready = 1'b1; step(); dout_ready = 1'b0;
    idle(1);
    if (got.size() > 0) chk("t4_drain", got[$], 8'h11);

    // Rerun with ready at the second frame's stop cycle: no overrun
    o0 = ovr_seen;
    send(good(8'h11, 1), FN, 1'b0, 0, 1'b0, 1'b0);
    send(good(8'h22, 1), FN, 1'b0, 0, 1'b0, 1'b1);
    idle(2);
    chk("t4b_dout", dout, 8'h22);
    chk("t4b_valid", dout_valid, 1);
    chk("t4b_ovr", ovr_seen, o0);
    if (got.size() > 0) chk("t4b_first", got[$], 8'h11);
    dout_ready = 1'b1;
    idle(2);
    if (got.size() > 0) chk("t4b_second", got[$], 8'h22);

    // Reset after start + 4 data bits, then 0xA5
    send(good(8'hFF, 1), 5, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(2);
    chk("t5_busy", busy, 0);
    chk("t5_dout", dout, 0);
    rst = 1'b0;
    idle(2);
    send(good(8'hA5, 1), FN, 1'b0, 0, 1'b0, 1'b0);
    idle(3);
    if (got.size() > 0) chk("t5_word", got[$], 8'hA5);

`ifdef SERIAL_DEFRAMER_PARITY_EN
    for (int gp = 0; gp < 4; gp += 3) begin
      n0 = got.size(); f0 = perr_seen;
      send(mk_frame(8'h07, 1, 1'b1, 1'b1), FN, 1'b0, gp, 1'b0, 1'b0);
      idle(3);
      chk("par_ok_count", got.size(), n0 + 1);
      if (got.size() > 0) chk("par_ok_word", got[$], 8'h07);
      send(mk_frame(8'h07, 1, 1'b1, 1'b0), FN, 1'b0, gp, 1'b0, 1'b0);
      idle(3);
      chk("par_bad_perr", perr_seen, f0 + 1);
      chk("par_bad_count", got.size(), n0 + 1);
    end
`else
    chk("no_parity_pulses", perr_seen, 0);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
